// File: rtl/fighter_pkg.sv
// Shared fighter-game types and constants: coordinate width, health limits,
// attack type codes and the hit-resolver state encoding.
package fighter_pkg;

    localparam int COORD_W  = 10;
    localparam int HEALTH_W = 8;

    localparam logic [HEALTH_W-1:0] HEALTH_MAX = 8'd100;

    // Attack type codes; any other code is treated as no attack.
    localparam logic [1:0] ATK_NONE = 2'd0;
    localparam logic [1:0] ATK1     = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HITSTUN = 2'd1,
        ST_KO      = 2'd2
    } resolver_state_e;

    // Health subtraction that bottoms out at zero instead of wrapping.
    function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] a,
                                                    input logic [HEALTH_W-1:0] b);
        return (a < b) ? '0 : a - b;
    endfunction

endpackage

// File: rtl/hitbox_overlap.sv
// Purely combinational hitbox-vs-hurtbox test. The attacker's hitbox sits in
// front of it in the facing direction; the defender's hurtbox starts at its x.
// All x arithmetic is 11-bit so nothing wraps; leftward boxes clamp at 0.
module hitbox_overlap
    import fighter_pkg::*;
#(
    parameter int HB_OFFSET  = 16,
    parameter int HB_WIDTH   = 24,
    parameter int HB_HEIGHT  = 32,
    parameter int HURT_WIDTH = 32
) (
    input  logic [COORD_W-1:0] attacker_x,
    input  logic [COORD_W-1:0] attacker_y,
    input  logic               attacker_facing,
    input  logic [COORD_W-1:0] defender_x,
    input  logic [COORD_W-1:0] defender_y,
    output logic               hit_geom
);

    localparam logic [COORD_W:0]   OFF_NEAR = (COORD_W+1)'(HB_OFFSET);
    localparam logic [COORD_W:0]   OFF_FAR  = (COORD_W+1)'(HB_OFFSET + HB_WIDTH);
    localparam logic [COORD_W:0]   HURT_W   = (COORD_W+1)'(HURT_WIDTH);
    localparam logic [COORD_W-1:0] Y_REACH  = COORD_W'(HB_HEIGHT);

    logic [COORD_W:0]   ax;
    logic [COORD_W:0]   hb_lo;
    logic [COORD_W:0]   hb_hi;
    logic [COORD_W:0]   hurt_lo;
    logic [COORD_W:0]   hurt_hi;
    logic [COORD_W-1:0] y_dist;
    logic               x_ok;
    logic               y_ok;

    assign ax      = {1'b0, attacker_x};
    assign hurt_lo = {1'b0, defender_x};
    assign hurt_hi = hurt_lo + HURT_W;

    // Hitbox edges and vertical distance; a fully clamped left box is empty.
    always_comb begin
        hb_lo = '0;
        hb_hi = '0;
        if (attacker_facing) begin
            hb_lo = ax + OFF_NEAR;
            hb_hi = ax + OFF_FAR;
        end else begin
            hb_lo = (ax > OFF_FAR)  ? ax - OFF_FAR  : '0;
            hb_hi = (ax > OFF_NEAR) ? ax - OFF_NEAR : '0;
        end
        y_dist = (attacker_y >= defender_y) ? attacker_y - defender_y
                                            : defender_y - attacker_y;
        x_ok   = (hb_lo < hurt_hi) && (hurt_lo < hb_hi);
        y_ok   = (y_dist < Y_REACH);
    end

    assign hit_geom = x_ok && y_ok;

endmodule

// File: rtl/attack_hit_resolver.sv
// Resolves the attacker's active hitbox against the defender once per video
// frame: applies damage or block chip, runs the hitstun countdown and latches KO.
module attack_hit_resolver
    import fighter_pkg::*;
#(
    parameter int HB_OFFSET      = 16,
    parameter int HB_WIDTH       = 24,
    parameter int HB_HEIGHT      = 32,
    parameter int HURT_WIDTH     = 32,
    parameter int ATK1_DMG       = 10,
    parameter int CHIP_DMG       = 2,
    parameter int HITSTUN_FRAMES = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                SCEN,
    input  logic                attack_active,
    input  logic                attack_busy,
    input  logic [1:0]          attack_type,
    input  logic [COORD_W-1:0]  attacker_x,
    input  logic [COORD_W-1:0]  attacker_y,
    input  logic                attacker_facing,
    input  logic [COORD_W-1:0]  defender_x,
    input  logic [COORD_W-1:0]  defender_y,
    input  logic                defender_blocking,
    output logic                hit_pulse,
    output logic                block_pulse,
    output logic [HEALTH_W-1:0] defender_health,
    output logic                defender_hitstun,
    output logic                defender_ko
);

    localparam int CNT_W = $clog2(HITSTUN_FRAMES + 1);

    resolver_state_e     state;
    logic [CNT_W-1:0]    hitstun_cnt;
    logic                hit_latched;
    logic                hit_geom;
    logic                connect;
    logic [HEALTH_W-1:0] dmg;
    logic [HEALTH_W-1:0] health_next;

    hitbox_overlap #(
        .HB_OFFSET  (HB_OFFSET),
        .HB_WIDTH   (HB_WIDTH),
        .HB_HEIGHT  (HB_HEIGHT),
        .HURT_WIDTH (HURT_WIDTH)
    ) u_overlap (
        .attacker_x      (attacker_x),
        .attacker_y      (attacker_y),
        .attacker_facing (attacker_facing),
        .defender_x      (defender_x),
        .defender_y      (defender_y),
        .hit_geom        (hit_geom)
    );

    // A hit lands only in IDLE, on a frame strobe, once per attack.
    assign connect = SCEN && attack_active && (attack_type == ATK1) && hit_geom
                     && !hit_latched && (state == ST_IDLE);

    assign dmg         = defender_blocking ? HEALTH_W'(CHIP_DMG) : HEALTH_W'(ATK1_DMG);
    assign health_next = sat_sub(defender_health, dmg);

    assign defender_hitstun = (state == ST_HITSTUN);
    assign defender_ko      = (state == ST_KO);

    // Frame-stepped resolver: hit latch, damage, hitstun countdown and KO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            hitstun_cnt     <= '0;
            hit_latched     <= 1'b0;
            hit_pulse       <= 1'b0;
            block_pulse     <= 1'b0;
            defender_health <= HEALTH_MAX;
        end else begin
            hit_pulse   <= 1'b0;
            block_pulse <= 1'b0;
            if (SCEN) begin
                if (connect) begin
                    hit_latched <= 1'b1;
                end else if (!attack_busy) begin
                    hit_latched <= 1'b0;
                end
                case (state)
                    ST_IDLE: begin
                        if (connect) begin
                            defender_health <= health_next;
                            hit_pulse       <= !defender_blocking;
                            block_pulse     <= defender_blocking;
                            if (health_next == '0) begin
                                state <= ST_KO;
                            end else if (!defender_blocking) begin
                                hitstun_cnt <= CNT_W'(HITSTUN_FRAMES);
                                state       <= ST_HITSTUN;
                            end
                        end
                    end
                    ST_HITSTUN: begin
                        if (hitstun_cnt <= CNT_W'(1)) begin
                            hitstun_cnt <= '0;
                            state       <= ST_IDLE;
                        end else begin
                            hitstun_cnt <= hitstun_cnt - CNT_W'(1);
                        end
                    end
                    ST_KO: begin
                        state <= ST_KO;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_attack_hit_resolver.sv
// Directed bench for attack_hit_resolver: a table of per-frame vectors with
// hand-computed expectations, plus hand-written multi-frame sequences.
module tb_attack_hit_resolver;

    logic       clk;
    logic       reset;
    logic       scen;
    logic       attack_active;
    logic       attack_busy;
    logic [1:0] attack_type;
    logic [9:0] attacker_x;
    logic [9:0] attacker_y;
    logic       attacker_facing;
    logic [9:0] defender_x;
    logic [9:0] defender_y;
    logic       defender_blocking;
    logic       hit_pulse;
    logic       block_pulse;
    logic [7:0] defender_health;
    logic       defender_hitstun;
    logic       defender_ko;

    int total_checks;
    int bad_checks;

    int hit_seen;
    int blk_seen;
    int late_seen;

    typedef struct {
        int rst;
        int n;
        int active;
        int busy;
        int typ;
        int ax;
        int face;
        int dx;
        int dy;
        int blk;
        int e_hit;
        int e_blk;
        int e_health;
        int e_hs;
        int e_ko;
    } vec_t;

    vec_t tbl[$];

    attack_hit_resolver dut (
        .clk               (clk),
        .reset             (reset),
        .SCEN              (scen),
        .attack_active     (attack_active),
        .attack_busy       (attack_busy),
        .attack_type       (attack_type),
        .attacker_x        (attacker_x),
        .attacker_y        (attacker_y),
        .attacker_facing   (attacker_facing),
        .defender_x        (defender_x),
        .defender_y        (defender_y),
        .defender_blocking (defender_blocking),
        .hit_pulse         (hit_pulse),
        .block_pulse       (block_pulse),
        .defender_health   (defender_health),
        .defender_hitstun  (defender_hitstun),
        .defender_ko       (defender_ko)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic addVec(input int rst, input int n, input int active, input int busy,
                          input int typ, input int ax, input int face, input int dx,
                          input int dy, input int blk, input int e_hit, input int e_blk,
                          input int e_health, input int e_hs, input int e_ko);
        vec_t v;
        v = '{rst, n, active, busy, typ, ax, face, dx, dy, blk,
              e_hit, e_blk, e_health, e_hs, e_ko};
        tbl.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        attack_active     = v.active[0];
        attack_busy       = v.busy[0];
        attack_type       = v.typ[1:0];
        attacker_x        = v.ax[9:0];
        attacker_y        = 10'd200;
        attacker_facing   = v.face[0];
        defender_x        = v.dx[9:0];
        defender_y        = v.dy[9:0];
        defender_blocking = v.blk[0];
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total_checks++;
        if (actual != expected) begin
            bad_checks++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        scen  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One frame: strobe SCEN for one clk, capture the pulse the clk after,
    // and capture again one clk later when both pulses must have dropped.
    task automatic runFrame();
        @(negedge clk);
        scen = 1'b1;
        @(negedge clk);
        scen      = 1'b0;
        hit_seen  = int'(hit_pulse);
        blk_seen  = int'(block_pulse);
        @(negedge clk);
        late_seen = int'(hit_pulse) + int'(block_pulse);
        @(negedge clk);
    endtask

    task automatic checkFrame(input string tag, input int e_hit, input int e_blk,
                              input int e_health, input int e_hs, input int e_ko);
        checkOutput({tag, ".hit"},     hit_seen,                e_hit);
        checkOutput({tag, ".blk"},     blk_seen,                e_blk);
        checkOutput({tag, ".late"},    late_seen,               0);
        checkOutput({tag, ".health"},  int'(defender_health),   e_health);
        checkOutput({tag, ".hitstun"}, int'(defender_hitstun),  e_hs);
        checkOutput({tag, ".ko"},      int'(defender_ko),       e_ko);
    endtask

    task automatic setAttack(input int active, input int busy, input int blk);
        attack_active     = active[0];
        attack_busy       = busy[0];
        attack_type       = 2'd1;
        defender_blocking = blk[0];
    endtask

    task automatic placeDefault();
        attacker_x      = 10'd100;
        attacker_y      = 10'd200;
        attacker_facing = 1'b1;
        defender_x      = 10'd120;
        defender_y      = 10'd200;
        setAttack(0, 0, 0);
    endtask

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        reset        = 1'b0;
        scen         = 1'b0;
        placeDefault();

        // rst n act busy typ ax face dx dy blk | hit blk health hs ko
        // Facing right, unblocked hit then 12-frame hitstun.
        addVec(1, 4, 0, 0, 0, 100, 1, 120, 200, 0,  0, 0, 100, 0, 0);
        addVec(0, 1, 1, 1, 1, 100, 1, 120, 200, 0,  1, 0,  90, 1, 0);
        addVec(0, 6, 1, 1, 1, 100, 1, 120, 200, 0,  0, 0,  90, 1, 0);
        addVec(0, 5, 0, 0, 0, 100, 1, 120, 200, 0,  0, 0,  90, 1, 0);
        addVec(0, 1, 0, 0, 0, 100, 1, 120, 200, 0,  0, 0,  90, 0, 0);
        addVec(0, 2, 0, 0, 0, 100, 1, 120, 200, 0,  0, 0,  90, 0, 0);
        // Blocked: chip only, one per attack, no hitstun.
        addVec(1, 4, 0, 0, 0, 100, 1, 120, 200, 1,  0, 0, 100, 0, 0);
        addVec(0, 1, 1, 1, 1, 100, 1, 120, 200, 1,  0, 1,  98, 0, 0);
        addVec(0, 6, 1, 1, 1, 100, 1, 120, 200, 1,  0, 0,  98, 0, 0);
        addVec(0, 2, 0, 0, 0, 100, 1, 120, 200, 1,  0, 0,  98, 0, 0);
        addVec(0, 1, 1, 1, 1, 100, 1, 120, 200, 1,  0, 1,  96, 0, 0);
        addVec(0, 1, 0, 0, 0, 100, 1, 120, 200, 1,  0, 0,  96, 0, 0);
        // Facing left: dx=60 hits, dx=84 only touches.
        addVec(1, 1, 0, 0, 0, 100, 0,  60, 200, 0,  0, 0, 100, 0, 0);
        addVec(0, 1, 1, 1, 1, 100, 0,  60, 200, 0,  1, 0,  90, 1, 0);
        addVec(1, 3, 1, 1, 1, 100, 0,  84, 200, 0,  0, 0, 100, 0, 0);
        // Attack types 2 and 3 behave as no attack.
        addVec(1, 2, 1, 1, 2, 100, 1, 120, 200, 0,  0, 0, 100, 0, 0);
        addVec(0, 2, 1, 1, 3, 100, 1, 120, 200, 0,  0, 0, 100, 0, 0);
        // Vertical reach: distance 32 misses, 31 connects (both sides).
        addVec(1, 2, 1, 1, 1, 100, 1, 120, 232, 0,  0, 0, 100, 0, 0);
        addVec(0, 1, 1, 1, 1, 100, 1, 120, 231, 0,  1, 0,  90, 1, 0);
        addVec(1, 1, 1, 1, 1, 100, 1, 120, 168, 0,  0, 0, 100, 0, 0);
        addVec(0, 1, 1, 1, 1, 100, 1, 120, 169, 0,  1, 0,  90, 1, 0);
        // Left hitbox clamped at 0: empty at ax=10, [0,14) at ax=30.
        addVec(1, 2, 1, 1, 1,  10, 0,   0, 200, 0,  0, 0, 100, 0, 0);
        addVec(0, 1, 1, 1, 1,  30, 0,   0, 200, 0,  1, 0,  90, 1, 0);
        // Facing right edges of hb [116,140).
        addVec(1, 1, 1, 1, 1, 100, 1, 140, 200, 0,  0, 0, 100, 0, 0);
        addVec(0, 1, 1, 1, 1, 100, 1, 139, 200, 0,  1, 0,  90, 1, 0);
        addVec(1, 1, 1, 1, 1, 100, 1,  84, 200, 0,  0, 0, 100, 0, 0);
        addVec(0, 1, 1, 1, 1, 100, 1,  85, 200, 0,  1, 0,  90, 1, 0);

        for (int r = 0; r < tbl.size(); r++) begin
            applyStimulus(tbl[r]);
            if (tbl[r].rst != 0) doReset();
            for (int f = 0; f < tbl[r].n; f++) begin
                runFrame();
                checkFrame($sformatf("row%0d.f%0d", r, f), tbl[r].e_hit, tbl[r].e_blk,
                           tbl[r].e_health, tbl[r].e_hs, tbl[r].e_ko);
            end
        end

        // Attack during hitstun is ignored; an attack held across expiry
        // connects only on the frame after hitstun ends.
        placeDefault();
        doReset();
        setAttack(1, 1, 0);
        runFrame();
        checkFrame("seq4.first", 1, 0, 90, 1, 0);
        setAttack(0, 0, 0);
        runFrame();
        checkFrame("seq4.f1", 0, 0, 90, 1, 0);
        setAttack(1, 1, 0);
        for (int f = 2; f <= 11; f++) begin
            runFrame();
            checkFrame($sformatf("seq4.f%0d", f), 0, 0, 90, 1, 0);
        end
        runFrame();
        checkFrame("seq4.expiry", 0, 0, 90, 0, 0);
        runFrame();
        checkFrame("seq4.second", 1, 0, 80, 1, 0);

        // Drive health down to 4 then land a hit: saturates to 0 and KO sticks.
        placeDefault();
        doReset();
        for (int i = 1; i <= 9; i++) begin
            setAttack(1, 1, 0);
            runFrame();
            checkFrame($sformatf("seq5.hit%0d", i), 1, 0, 100 - 10 * i, 1, 0);
            setAttack(0, 0, 0);
            repeat (12) runFrame();
            checkOutput($sformatf("seq5.recover%0d", i), int'(defender_hitstun), 0);
        end
        for (int j = 1; j <= 3; j++) begin
            setAttack(1, 1, 1);
            runFrame();
            checkFrame($sformatf("seq5.block%0d", j), 0, 1, 10 - 2 * j, 0, 0);
            setAttack(0, 0, 1);
            runFrame();
        end
        setAttack(1, 1, 0);
        runFrame();
        checkFrame("seq5.ko", 1, 0, 0, 0, 1);
        setAttack(0, 0, 0);
        runFrame();
        setAttack(1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            runFrame();
            checkFrame($sformatf("seq5.post%0d", k), 0, 0, 0, 0, 1);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("seq5.rst.health", int'(defender_health), 100);
        checkOutput("seq5.rst.ko",     int'(defender_ko),     0);

        // Reset without SCEN in the middle of hitstun.
        placeDefault();
        doReset();
        setAttack(1, 1, 0);
        runFrame();
        checkFrame("seq6.hit", 1, 0, 90, 1, 0);
        setAttack(0, 0, 0);
        repeat (6) runFrame();
        checkFrame("seq6.mid", 0, 0, 90, 1, 0);
        @(negedge clk);
        reset = 1'b1;
        scen  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("seq6.health",  int'(defender_health),  100);
        checkOutput("seq6.hitstun", int'(defender_hitstun), 0);
        checkOutput("seq6.pulses",  int'(hit_pulse) + int'(block_pulse), 0);
        checkOutput("seq6.ko",      int'(defender_ko),      0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
